// File: rtl/frame_buffer_multi.sv
// Multi-buffered frame store: a rasterizer draws into one buffer while the DVI
// side scans another out linearly; buffer roles rotate only at scanout frame end.
module frame_buffer_multi #(
    parameter int H_RES         = 640,
    parameter int V_RES         = 480,
    parameter int COLOR_W       = 3,
    parameter int NUM_BUFS      = 2,
    parameter int CLEAR_ON_SWAP = 1,
    parameter logic [COLOR_W-1:0] CLEAR_COLOR = '0,
    localparam int XW = $clog2(H_RES),
    localparam int YW = $clog2(V_RES),
    localparam int AW = $clog2(H_RES * V_RES)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rast_pixel_rdy,
    input  logic [COLOR_W-1:0] rast_color_input,
    input  logic [XW-1:0]      rast_width,
    input  logic [YW-1:0]      rast_height,
    input  logic               rast_done,
    input  logic               next_frame_switch,
    output logic               read_rast_pixel_rdy,
    output logic               rast_oob,
    input  logic               dvi_fifo_full,
    output logic [COLOR_W-1:0] dvi_color_out,
    output logic               dvi_fifo_write_enable,
    output logic               dvi_frame_start,
    output logic               swap_pending
);
    localparam int DEPTH = H_RES * V_RES;
    localparam int BW = $clog2(NUM_BUFS);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    typedef enum logic [1:0] {CLEAR, DRAW, WAIT_SWAP} state_t;
    localparam state_t FILL = state_t'((CLEAR_ON_SWAP != 0) ? CLEAR : DRAW);

    state_t state, state_next;

    logic [COLOR_W-1:0] mem [NUM_BUFS][DEPTH];

    logic [BW-1:0] disp_idx, draw_idx, rdy_idx, third_idx;
    logic          rdy_valid;
    logic [AW-1:0] clr_addr, scan_addr, pix_addr;
    logic          in_range, complete, issue, frame_end;
    logic          promote, swap2, swap3;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [COLOR_W-1:0] wr_data;

    assign pix_addr  = AW'(rast_height) * AW'(H_RES) + AW'(rast_width);
    assign in_range  = (32'(rast_width) < H_RES) && (32'(rast_height) < V_RES);
    assign complete  = (state == DRAW) && rast_done && next_frame_switch;
    assign issue     = !dvi_fifo_full;
    assign frame_end = issue && (scan_addr == LAST);

    // With three buffers the roles are a permutation of 0..2, so the one
    // not displayed and not drawn is whichever index is left over.
    assign third_idx = BW'(3 - 32'(disp_idx) - 32'(draw_idx));

    assign promote = (NUM_BUFS == 3) && !rdy_valid && (complete || state == WAIT_SWAP);
    assign swap3   = (NUM_BUFS == 3) && rdy_valid && frame_end;
    assign swap2   = (NUM_BUFS == 2) && (state == WAIT_SWAP) && frame_end;

    assign read_rast_pixel_rdy = (state == DRAW);
    assign swap_pending        = (state == WAIT_SWAP) || rdy_valid;

    always_comb begin
        state_next = state;
        case (state)
            CLEAR:     if (clr_addr == LAST) state_next = DRAW;
            DRAW:      if (complete) state_next = promote ? FILL : WAIT_SWAP;
            WAIT_SWAP: if (swap2 || promote) state_next = FILL;
            default:   state_next = FILL;
        endcase
    end

    always_comb begin
        wr_en   = 1'b0;
        wr_addr = clr_addr;
        wr_data = CLEAR_COLOR;
        if (state == CLEAR) begin
            wr_en = 1'b1;
        end else if (state == DRAW && rast_pixel_rdy && in_range) begin
            wr_en   = 1'b1;
            wr_addr = pix_addr;
            wr_data = rast_color_input;
        end
    end

    // Storage is deliberately left out of reset; only the draw buffer is written.
    always_ff @(posedge clk) begin
        if (wr_en) mem[draw_idx][wr_addr] <= wr_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= FILL;
            clr_addr  <= '0;
            disp_idx  <= '0;
            draw_idx  <= BW'(1);
            rdy_idx   <= BW'(NUM_BUFS - 1);
            rdy_valid <= 1'b0;
            rast_oob  <= 1'b0;
        end else begin
            state    <= state_next;
            clr_addr <= (state == CLEAR && clr_addr != LAST) ? clr_addr + AW'(1) : '0;
            rast_oob <= (state == DRAW) && rast_pixel_rdy && !in_range;
            if (swap2) begin
                disp_idx <= draw_idx;
                draw_idx <= disp_idx;
            end
            if (swap3) begin
                disp_idx  <= rdy_idx;
                rdy_valid <= 1'b0;
            end
            if (promote) begin
                rdy_idx   <= draw_idx;
                draw_idx  <= third_idx;
                rdy_valid <= 1'b1;
            end
        end
    end

    // The read at frame end still uses the old disp_idx; the swap lands on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_addr             <= '0;
            dvi_color_out         <= '0;
            dvi_fifo_write_enable <= 1'b0;
            dvi_frame_start       <= 1'b0;
        end else begin
            dvi_fifo_write_enable <= issue;
            dvi_frame_start       <= issue && (scan_addr == '0);
            if (issue) begin
                dvi_color_out <= mem[disp_idx][scan_addr];
                scan_addr     <= frame_end ? '0 : scan_addr + AW'(1);
            end
        end
    end
endmodule

// File: tb/tb_frame_buffer_multi.sv
// Drives a double-buffered 4x2 instance and a triple-buffered 5x2 instance from
// shared stimulus and checks both against a frame-content reference model.
module tb_frame_buffer_multi;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       pix_rdy = 1'b0;
    logic [2:0] col = '0;
    logic [2:0] x = '0;
    logic       y = 1'b0;
    logic       done = 1'b0, sw = 1'b0, full = 1'b0;

    logic [1:0]      rdy_o, oob_o, we_o, fs_o, sp_o;
    logic [1:0][2:0] col_o;

    frame_buffer_multi #(.H_RES(4), .V_RES(2), .COLOR_W(3), .NUM_BUFS(2),
                         .CLEAR_ON_SWAP(1), .CLEAR_COLOR(3'd0)) dut2 (
        .clk(clk), .rst(rst), .rast_pixel_rdy(pix_rdy), .rast_color_input(col),
        .rast_width(x[1:0]), .rast_height(y), .rast_done(done), .next_frame_switch(sw),
        .read_rast_pixel_rdy(rdy_o[0]), .rast_oob(oob_o[0]), .dvi_fifo_full(full),
        .dvi_color_out(col_o[0]), .dvi_fifo_write_enable(we_o[0]),
        .dvi_frame_start(fs_o[0]), .swap_pending(sp_o[0]));

    // Five-pixel lines give the 3-bit x port room to carry out-of-range values.
    frame_buffer_multi #(.H_RES(5), .V_RES(2), .COLOR_W(3), .NUM_BUFS(3),
                         .CLEAR_ON_SWAP(1), .CLEAR_COLOR(3'd5)) dut3 (
        .clk(clk), .rst(rst), .rast_pixel_rdy(pix_rdy), .rast_color_input(col),
        .rast_width(x), .rast_height(y), .rast_done(done), .next_frame_switch(sw),
        .read_rast_pixel_rdy(rdy_o[1]), .rast_oob(oob_o[1]), .dvi_fifo_full(full),
        .dvi_color_out(col_o[1]), .dvi_fifo_write_enable(we_o[1]),
        .dvi_frame_start(fs_o[1]), .swap_pending(sp_o[1]));

    int n_cmp = 0, n_err = 0;

    int hres[2]    = '{4, 5};
    int depth[2]   = '{8, 10};
    int clr_col[2] = '{0, 5};
    int nbufs[2]   = '{2, 3};

    // Frame contents by role: displayed, being drawn, finished-and-queued.
    int disp_c[2][16], draw_c[2][16], ready_c[2][16];
    bit known[2];
    int m_p[2], m_clr[2];
    bit m_wait[2], m_rv[2];
    bit e_we[2], e_fs[2], e_oob[2], e_kn[2];
    int e_col[2];

    task automatic chk(input string tag, input int d, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s[dut%0d] observed=%0h expected=%0h", tag, d, obs, exp);
        end
    endtask

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_p[d] = 0; m_clr[d] = depth[d]; m_wait[d] = 0; m_rv[d] = 0; known[d] = 0;
            e_we[d] = 0; e_fs[d] = 0; e_oob[d] = 0; e_kn[d] = 0; e_col[d] = 0;
            for (int i = 0; i < 16; i++) draw_c[d][i] = clr_col[d];
        end
    endfunction

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            bit rdy, fe, cmp, rv, wt;
            int xi;
            rdy = !m_wait[d] && m_clr[d] == 0;
            fe  = !full && m_p[d] == depth[d] - 1;
            cmp = rdy && done && sw;
            rv  = m_rv[d];
            wt  = m_wait[d];
            e_we[d]  = !full;
            e_fs[d]  = !full && m_p[d] == 0;
            e_col[d] = disp_c[d][m_p[d]];
            e_kn[d]  = known[d];
            e_oob[d] = 0;
            if (rdy && pix_rdy) begin
                xi = (d == 0) ? int'(x[1:0]) : int'(x);
                if (xi < hres[d]) draw_c[d][int'(y) * hres[d] + xi] = int'(col);
                else e_oob[d] = 1;
            end
            if (!full) m_p[d] = fe ? 0 : m_p[d] + 1;
            if (m_clr[d] > 0) m_clr[d]--;
            if (nbufs[d] == 2) begin
                if (wt && fe) begin
                    for (int i = 0; i < 16; i++) begin
                        disp_c[d][i] = draw_c[d][i];
                        draw_c[d][i] = clr_col[d];
                    end
                    known[d] = 1; m_wait[d] = 0; m_clr[d] = depth[d];
                end
                if (cmp) m_wait[d] = 1;
            end else begin
                if (rv && fe) begin
                    for (int i = 0; i < 16; i++) disp_c[d][i] = ready_c[d][i];
                    known[d] = 1; m_rv[d] = 0;
                end
                if ((cmp && !rv) || (wt && !rv)) begin
                    for (int i = 0; i < 16; i++) begin
                        ready_c[d][i] = draw_c[d][i];
                        draw_c[d][i]  = clr_col[d];
                    end
                    m_rv[d] = 1; m_wait[d] = 0; m_clr[d] = depth[d];
                end else if (cmp) begin
                    m_wait[d] = 1;
                end
            end
        end
    endtask

    task automatic check_outs();
        for (int d = 0; d < 2; d++) begin
            chk("pixel_rdy", d, rdy_o[d], !m_wait[d] && m_clr[d] == 0);
            chk("swap_pending", d, sp_o[d], m_wait[d] || m_rv[d]);
            chk("oob", d, oob_o[d], e_oob[d]);
            chk("write_enable", d, we_o[d], e_we[d]);
            chk("frame_start", d, fs_o[d], e_fs[d]);
            if (e_we[d] && e_kn[d]) chk("color", d, col_o[d], e_col[d]);
        end
    endtask

    task automatic rst_check();
        for (int d = 0; d < 2; d++) begin
            chk("rst_pixel_rdy", d, rdy_o[d], 0);
            chk("rst_swap_pending", d, sp_o[d], 0);
            chk("rst_oob", d, oob_o[d], 0);
            chk("rst_write_enable", d, we_o[d], 0);
            chk("rst_frame_start", d, fs_o[d], 0);
            chk("rst_color", d, col_o[d], 0);
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        check_outs();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst_check();
        rst = 0;

        // reset in the middle of the first clear
        repeat (3) step();
        #2 rst = 1;
        #1 rst_check();
        model_reset();
        @(posedge clk);
        #1 rst_check();
        rst = 0;
        repeat (12) step();

        // done without switch permission is ignored
        done = 1; sw = 0; step(); done = 0;

        for (int i = 0; i < 8; i++) begin
            pix_rdy = 1; col = 3'(i); x = 3'(i % 4); y = 1'(i / 4);
            step();
        end
        pix_rdy = 0;
        done = 1; sw = 1; step(); done = 0; sw = 0;
        repeat (24) step();

        // three-cycle FIFO backpressure mid-frame
        repeat (3) step();
        full = 1; repeat (3) step(); full = 0;
        repeat (20) step();

        pix_rdy = 1;
        x = 3'd5; y = 0; col = 3'd6; step();
        x = 3'd7; y = 1; col = 3'd1; step();
        x = 3'd4; y = 0; col = 3'd2; step();
        pix_rdy = 0;
        repeat (24) step();

        // two completions while scanout is stalled: second one must wait
        full = 1;
        pix_rdy = 1; x = 3'd1; y = 1; col = 3'($urandom); step(); pix_rdy = 0;
        done = 1; sw = 1; step(); done = 0; sw = 0;
        repeat (11) step();
        pix_rdy = 1; x = 3'd2; y = 1; col = 3'd4; step(); pix_rdy = 0;
        done = 1; sw = 1; step(); done = 0; sw = 0;
        repeat (2) step();
        full = 0;
        repeat (40) step();

        for (int i = 0; i < 900; i++) begin
            pix_rdy = ($urandom_range(0, 9) < 7);
            col     = 3'($urandom);
            x       = 3'($urandom);
            y       = 1'($urandom);
            done    = ($urandom_range(0, 15) == 0);
            sw      = 1'($urandom);
            full    = ($urandom_range(0, 4) == 0);
            step();
        end
        pix_rdy = 0; done = 0; sw = 0; full = 0;
        repeat (30) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
